// File: rtl/instr_prefetch_queue.sv
// Fetch-side prefetch queue: issues sequential imem addresses and buffers {pc, instr} pairs.
// Define PFQ_PERF_EN to add saturating redirect and empty-cycle performance counters.
module instr_prefetch_queue #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             out_valid,
  output logic [PC_W-1:0]  out_pc,
  output logic [INS_W-1:0] out_instr,
  input  logic             out_ready
`ifdef PFQ_PERF_EN
  ,
  output logic [15:0]      perf_redirects,
  output logic [15:0]      perf_empty_cycles
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  rsp_pc_q, rsp_pc_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PC_W-1:0]  pc_mem_q  [DEPTH];
  logic [INS_W-1:0] ins_mem_q [DEPTH];

  logic [CNT_W-1:0] occupancy;
  logic             issue;
  logic             push;
  logic             pop;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]  : '0;
  assign out_instr = out_valid ? ins_mem_q[rd_ptr_q] : '0;

  // Credit check counts the in-flight read so a response always has a free slot.
  always_comb begin
    occupancy  = count_q + CNT_W'(inflight_q);
    issue      = !redirect && (occupancy < CNT_W'(DEPTH));
    push       = !redirect && inflight_q;
    pop        = !redirect && out_valid && out_ready;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = issue;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + PC_W'(4);
        rsp_pc_d   = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= '0;
      rsp_pc_q   <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]  <= rsp_pc_q;
      ins_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  push_into_full: assert property (@(posedge clk) disable iff (!reset)
    !(push && (count_q == CNT_W'(DEPTH))));

`ifdef PFQ_PERF_EN
  logic [15:0] perf_redirects_q, perf_redirects_d;
  logic [15:0] perf_empty_q, perf_empty_d;

  always_comb begin
    perf_redirects_d = perf_redirects_q;
    perf_empty_d     = perf_empty_q;
    if (redirect && (perf_redirects_q != 16'hFFFF))
      perf_redirects_d = perf_redirects_q + 16'd1;
    if (!out_valid && out_ready && (perf_empty_q != 16'hFFFF))
      perf_empty_d = perf_empty_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_redirects_q <= '0;
      perf_empty_q     <= '0;
    end else begin
      perf_redirects_q <= perf_redirects_d;
      perf_empty_q     <= perf_empty_d;
    end
  end

  assign perf_redirects    = perf_redirects_q;
  assign perf_empty_cycles = perf_empty_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomized self-checking bench for instr_prefetch_queue against a queue-level reference model.
// Perf counter checks are compiled only when PFQ_PERF_EN is defined.
module tb_instr_prefetch_queue;
  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam int DEPTH = 4;
  localparam int BW    = 1 + PC_W + INS_W + PC_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_rdata;
  logic             out_valid;
  logic [PC_W-1:0]  out_pc;
  logic [INS_W-1:0] out_instr;
  logic             out_ready;
`ifdef PFQ_PERF_EN
  logic [15:0]      perf_redirects;
  logic [15:0]      perf_empty_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of PCs, one optional outstanding read, next fetch PC.
  int m_q[$];
  bit m_inflight;
  int m_rsp_pc;
  int m_fetch;
  int m_red;
  int m_empty;

  instr_prefetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_ready   (out_ready)
`ifdef PFQ_PERF_EN
    ,
    .perf_redirects    (perf_redirects),
    .perf_empty_cycles (perf_empty_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [INS_W-1:0] instr_of(input int pc);
    return 32'h9E3779B1 * pc + 32'h0000_0013;
  endfunction

  // Synchronous instruction memory: data appears the cycle after the address is sampled.
  always @(posedge clk) imem_rdata <= instr_of(int'(imem_addr));

  function automatic logic [BW-1:0] dut_view();
    return {out_valid, out_pc, out_instr, imem_addr};
  endfunction

  function automatic logic [BW-1:0] model_view();
    logic            v;
    logic [PC_W-1:0] p;
    logic [INS_W-1:0] i;
    v = (m_q.size() != 0);
    p = v ? PC_W'(m_q[0]) : '0;
    i = v ? instr_of(m_q[0]) : '0;
    return {v, p, i, PC_W'(m_fetch)};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_inflight = 0;
    m_rsp_pc   = 0;
    m_fetch    = 0;
    m_red      = 0;
    m_empty    = 0;
  endtask

  // One clock: model steps from the inputs seen at the edge, then wait for the sampling edge.
  task automatic tick();
    int occ;
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      occ = m_q.size() + (m_inflight ? 1 : 0);
      if (m_q.size() == 0 && out_ready && m_empty < 65535) m_empty++;
      if (redirect) begin
        if (m_red < 65535) m_red++;
        m_q.delete();
        m_inflight = 0;
        m_fetch    = (int'(redirect_pc) / 4) * 4;
      end else begin
        if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
        if (m_inflight) m_q.push_back(m_rsp_pc);
        if (occ < DEPTH) begin
          m_rsp_pc   = m_fetch;
          m_inflight = 1;
          m_fetch    = (m_fetch + 4) % (1 << PC_W);
        end else begin
          m_inflight = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_pc, out_instr, imem_addr} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", dut_view());
    end
  endtask

  task automatic test_startup();
    apply_reset();
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("[TB] FAIL startup_cyc%0d: got %h expected %h", c, dut_view(), model_view());
      end
      checks++;
      if (imem_addr !== PC_W'(4 * c)) begin
        errors++;
        $display("[TB] FAIL startup_addr%0d: got %h expected %h", c, imem_addr, PC_W'(4 * c));
      end
      if (c >= 2) begin
        checks++;
        if (!out_valid || out_pc !== PC_W'(4 * (c - 2))) begin
          errors++;
          $display("[TB] FAIL startup_head%0d: got v=%b pc=%h expected v=1 pc=%h",
                   c, out_valid, out_pc, PC_W'(4 * (c - 2)));
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL startup_empty%0d: got v=%b expected v=0", c, out_valid);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    tick();
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("[TB] FAIL stall_cyc%0d: got %h expected %h", c, dut_view(), model_view());
      end
    end
    checks++;
    if (imem_addr !== 9'h010 || !out_valid || out_pc !== 9'h000) begin
      errors++;
      $display("[TB] FAIL stall_frozen: got addr=%h v=%b pc=%h expected addr=010 v=1 pc=000",
               imem_addr, out_valid, out_pc);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (!out_valid || out_pc !== PC_W'(4 * k) || out_instr !== instr_of(4 * k)) begin
        errors++;
        $display("[TB] FAIL drain%0d: got v=%b pc=%h ins=%h expected pc=%h ins=%h",
                 k, out_valid, out_pc, out_instr, PC_W'(4 * k), instr_of(4 * k));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    bit ready_state;
    apply_reset();
    tick();
    tick();
    out_ready   = 1'b0;
    ready_state = 1'b0;
    for (int c = 0; c < 10 && !ready_state; c++) begin
      tick();
      ready_state = (m_q.size() == 3) && m_inflight;
    end
    checks++;
    if (!ready_state || dut_view() !== model_view()) begin
      errors++;
      $display("[TB] FAIL redirect_setup: got %h expected %h (reached=%b)",
               dut_view(), model_view(), ready_state);
    end
    redirect    = 1'b1;
    redirect_pc = 9'h040 | PC_W'($urandom_range(0, 3));
    out_ready   = 1'($urandom_range(0, 1));
    tick();
    redirect  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 9'h040) begin
      errors++;
      $display("[TB] FAIL redirect_next: got v=%b addr=%h expected v=0 addr=040", out_valid, imem_addr);
    end
    tick();
    tick();
    checks++;
    if (!out_valid || out_pc !== 9'h040 || out_instr !== instr_of(32'h40)) begin
      errors++;
      $display("[TB] FAIL redirect_target: got v=%b pc=%h expected v=1 pc=040", out_valid, out_pc);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (dut_view() !== model_view() || (out_valid && out_pc < 9'h040)) begin
        errors++;
        $display("[TB] FAIL redirect_follow%0d: got %h expected %h", c, dut_view(), model_view());
      end
    end
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] got[$];
    logic [PC_W-1:0] want [4];
    want = '{9'h1F8, 9'h1FC, 9'h000, 9'h004};
    apply_reset();
    tick();
    redirect    = 1'b1;
    redirect_pc = 9'h1F8;
    tick();
    redirect = 1'b0;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      if (out_valid) got.push_back(out_pc);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= got.size()) begin
        errors++;
        $display("[TB] FAIL wrap_pc%0d: got nothing expected %h", k, want[k]);
      end else if (got[k] !== want[k]) begin
        errors++;
        $display("[TB] FAIL wrap_pc%0d: got %h expected %h", k, got[k], want[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    checks++;
    if (dut_view() !== model_view()) begin
      errors++;
      $display("[TB] FAIL async_full: got %h expected %h", dut_view(), model_view());
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== '0 || out_pc !== '0 || out_instr !== '0) begin
      errors++;
      $display("[TB] FAIL async_immediate: got v=%b addr=%h pc=%h ins=%h expected all 0",
               out_valid, imem_addr, out_pc, out_instr);
    end
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 9'h004) begin
      errors++;
      $display("[TB] FAIL async_restart1: got v=%b addr=%h expected v=0 addr=004", out_valid, imem_addr);
    end
    tick();
    checks++;
    if (!out_valid || out_pc !== 9'h000) begin
      errors++;
      $display("[TB] FAIL async_restart2: got v=%b pc=%h expected v=1 pc=000", out_valid, out_pc);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = PC_W'($urandom);
      tick();
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("[TB] FAIL random_cyc%0d: got %h expected %h", c, dut_view(), model_view());
      end
    end
    redirect = 1'b0;
  endtask

`ifdef PFQ_PERF_EN
  task automatic test_perf();
    apply_reset();
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if (perf_empty_cycles !== 16'd2 || perf_redirects !== 16'd0) begin
      errors++;
      $display("[TB] FAIL perf_startup: got red=%0d empty=%0d expected red=0 empty=2",
               perf_redirects, perf_empty_cycles);
    end
    for (int r = 0; r < 3; r++) begin
      redirect    = 1'b1;
      redirect_pc = PC_W'(32'h080 + 32'h20 * r);
      tick();
      redirect = 1'b0;
      for (int c = 0; c < 5; c++) tick();
    end
    checks++;
    if (perf_redirects !== 16'd3 || perf_empty_cycles !== 16'd8) begin
      errors++;
      $display("[TB] FAIL perf_redirects: got red=%0d empty=%0d expected red=3 empty=8",
               perf_redirects, perf_empty_cycles);
    end
    checks++;
    if (perf_redirects !== 16'(m_red) || perf_empty_cycles !== 16'(m_empty)) begin
      errors++;
      $display("[TB] FAIL perf_model: got red=%0d empty=%0d expected red=%0d empty=%0d",
               perf_redirects, perf_empty_cycles, m_red, m_empty);
    end
  endtask
`endif

  initial begin
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b0;
    model_reset();
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_random();
`ifdef PFQ_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
